seg7_mux_counter: RTL

Parametrised successor to the single-digit 1 Hz counter. Drives an N-digit multiplexed common-anode 7-segment display on a Basys3-class board. Holds a cascaded BCD up/down counter that advances on a programmable tick, with pause, clear and leading-zero blanking. Output polarity is active-low for segments and anodes.

---
 rtl/seg7_mux_counter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seg7_mux_counter.sv
// Multiplexed N-digit common-anode 7-segment driver with a cascaded BCD
// up/down counter, programmable tick, clear, and leading-zero blanking.
module seg7_mux_counter #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TICK_HZ    = 1,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned DIGITS     = 4,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  CLR,
  output logic [6:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  DP,
  output logic [4*DIGITS-1:0]   VALUE,
  output logic                  WRAP
);

  localparam int unsigned TickDiv = CLK_HZ / TICK_HZ;
  localparam int unsigned SlotDiv = CLK_HZ / REFRESH_HZ;
  localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned SlotW   = (SlotDiv > 1) ? $clog2(SlotDiv) : 1;
  localparam int unsigned IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (TickDiv < 1) begin : g_bad_tick
    $error("CLK_HZ/TICK_HZ must be at least 1");
  end
  if (SlotDiv < 1) begin : g_bad_slot
    $error("CLK_HZ/REFRESH_HZ must be at least 1");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("DIGITS must be in 1..8");
  end

  logic [TickW-1:0]      tick_q;
  logic                  tick;
  logic [SlotW-1:0]      slot_q;
  logic                  slot_end;
  logic [IdxW-1:0]       idx_q;
  logic [4*DIGITS-1:0]   value_q, value_d;
  logic                  wrap_q;
  logic                  carry;
  logic [3:0]            digit;
  logic                  blank;
  logic                  upper_zero;
  logic [6:0]            seg_d;
  logic [DIGITS-1:0]     an_d;

  assign tick     = (tick_q == TickW'(TickDiv - 1));
  assign slot_end = (slot_q == SlotW'(SlotDiv - 1));

  // Tick divider: free-running regardless of EN, restarted by CLR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_q <= '0;
    end else if (CLR || tick) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + TickW'(1);
    end
  end

  // Ripple BCD increment/decrement; carry out of the top digit means wrap.
  always_comb begin
    value_d = value_q;
    carry   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (UP) begin
          // Non-BCD digits roll to 0 with carry, same as 9.
          if (value_q[4*k +: 4] >= 4'd9) begin
            value_d[4*k +: 4] = 4'd0;
          end else begin
            value_d[4*k +: 4] = value_q[4*k +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (value_q[4*k +: 4] == 4'd0) begin
            value_d[4*k +: 4] = 4'd9;
          end else begin
            value_d[4*k +: 4] = value_q[4*k +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Count register and one-cycle wrap pulse; CLR wins over tick.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else if (CLR) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else if (tick && EN) begin
      value_q <= value_d;
      wrap_q  <= carry;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  // Refresh slot timer and digit mux index.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else if (slot_end) begin
      slot_q <= '0;
      idx_q  <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end else begin
      slot_q <= slot_q + SlotW'(1);
    end
  end

  // Select the current digit, decide blanking, decode segments and anodes.
  always_comb begin
    digit      = 4'd0;
    blank      = 1'b0;
    upper_zero = 1'b1;
    an_d       = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (value_q[4*k +: 4] != 4'd0) upper_zero = 1'b0;
      if (IdxW'(k) == idx_q) begin
        digit   = value_q[4*k +: 4];
        an_d[k] = 1'b0;
        if (k != 0) blank = BLANK_LZ && upper_zero;
      end
    end
    case (digit)
      4'd0:    seg_d = 7'h40;
      4'd1:    seg_d = 7'h79;
      4'd2:    seg_d = 7'h24;
      4'd3:    seg_d = 7'h30;
      4'd4:    seg_d = 7'h19;
      4'd5:    seg_d = 7'h12;
      4'd6:    seg_d = 7'h02;
      4'd7:    seg_d = 7'h78;
      4'd8:    seg_d = 7'h00;
      4'd9:    seg_d = 7'h10;
      default: seg_d = 7'h7F;
    endcase
    if (blank) seg_d = 7'h7F;
  end

  // SEG and AN registered together so a digit never shows on the wrong anode.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SEG <= 7'h7F;
      AN  <= '1;
    end else begin
      SEG <= seg_d;
      AN  <= an_d;
    end
  end

  assign VALUE = value_q;
  assign WRAP  = wrap_q;
  assign DP    = 1'b1;

endmodule
